// File: rtl/cov_collect_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cov_collect_ctrl_if                                             |
// | Purpose  : Bundles the command, source-scan and result signals of the      |
// |            coverage collection controller.                                 |
// | Ports    : none (signal bundle only)                                       |
// |   cmd_*  : command request from the command master (START/STOP/SCAN/CLEAR) |
// |   cov_*  : global enable and clear pulse broadcast to all sources          |
// |   src_*  : time-multiplexed read port into the instrumented module array   |
// |   res_*  : scan result handshake back to the command master                |
// |   busy   : controller is not idle                                          |
// | Modports : slave = controller side, master = command master / source side |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface cov_collect_ctrl_if #(
  parameter int NUM_SRC = 4,
  parameter int PT_W    = 16,
  parameter int CNT_W   = 16
);
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int NW = $clog2(PT_W + 1);

  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic             cmd_ready;
  logic             cov_en;
  logic             cov_clr;
  logic [SW-1:0]    src_sel;
  logic [PT_W-1:0]  src_hit;
  logic [NW-1:0]    src_npts;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_hit;
  logic [CNT_W-1:0] res_total;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_op, src_hit, src_npts, res_ready,
    output cmd_ready, cov_en, cov_clr, src_sel, res_valid, res_hit, res_total, busy
  );

  modport master (
    output cmd_valid, cmd_op, src_hit, src_npts, res_ready,
    input  cmd_ready, cov_en, cov_clr, src_sel, res_valid, res_hit, res_total, busy
  );
endinterface
`default_nettype wire

// File: rtl/cov_collect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cov_collect_ctrl                                                |
// | Purpose  : Coverage collection sequencer. Owns the global coverage enable  |
// |            and clear, and scans every source's hit bitmap over a shared    |
// |            read port to produce covered / implemented point totals.        |
// | Ports    : clock, reset (synchronous, active-high)                         |
// |            bus (slave modport of cov_collect_ctrl_if):                     |
// |              cmd_valid/cmd_op/cmd_ready  command handshake                 |
// |              cov_en/cov_clr              broadcast to all sources          |
// |              src_sel/src_hit/src_npts    source read port (1-cycle lat.)   |
// |              res_valid/res_ready/res_hit/res_total  result handshake       |
// |              busy                        controller not idle               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cov_collect_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int PT_W    = 16,
  parameter int CNT_W   = 16
) (
  input  logic                clock,
  input  logic                reset,
  cov_collect_ctrl_if.slave   bus
);
  localparam int SW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int NW    = $clog2(PT_W + 1);
  localparam int SUM_W = ((CNT_W > NW) ? CNT_W : NW) + 1;

  localparam logic [SW-1:0] LAST_SEL = SW'(NUM_SRC - 1);
  localparam logic [NW-1:0] PT_MAX   = NW'(PT_W);

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_SCAN  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_RESULT = 3'd3,
    ST_CLEAR  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             en_q, en_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] tot_q, tot_d;

  logic [NW-1:0]    npts_clamp;
  logic [NW-1:0]    pop;
  logic             sample;
  logic             cmd_fire;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [NW-1:0]    b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s[SUM_W-1:CNT_W] != '0) return '1;
    return s[CNT_W-1:0];
  endfunction

  // Count only the hit bits below the (clamped) implemented-point count.
  always_comb begin
    npts_clamp = (bus.src_npts > PT_MAX) ? PT_MAX : bus.src_npts;
    pop        = '0;
    for (int i = 0; i < PT_W; i++) begin
      if (bus.src_hit[i] && (NW'(i) < npts_clamp)) pop = pop + NW'(1);
    end
  end

  assign cmd_fire = bus.cmd_valid && bus.cmd_ready;

  // Read data lags src_sel by one cycle: the first SCAN cycle only issues the
  // select, every later SCAN cycle and the DRAIN cycle consume a source.
  assign sample = ((state_q == ST_SCAN) && (sel_q != '0)) || (state_q == ST_DRAIN);

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    sel_d   = sel_q;
    hit_d   = hit_q;
    tot_d   = tot_q;

    if (sample) begin
      hit_d = sat_add(hit_q, pop);
      tot_d = sat_add(tot_q, npts_clamp);
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (bus.cmd_op)
            OP_START: en_d = 1'b1;
            OP_STOP:  en_d = 1'b0;
            OP_SCAN: begin
              hit_d   = '0;
              tot_d   = '0;
              sel_d   = '0;
              state_d = ST_SCAN;
            end
            OP_CLEAR: state_d = ST_CLEAR;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_SCAN: begin
        if (sel_q == LAST_SEL) state_d = ST_DRAIN;
        else                   sel_d   = sel_q + SW'(1);
      end
      ST_DRAIN:  state_d = ST_RESULT;
      ST_RESULT: if (bus.res_ready) state_d = ST_IDLE;
      ST_CLEAR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      sel_q   <= '0;
      hit_q   <= '0;
      tot_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      hit_q   <= hit_d;
      tot_q   <= tot_d;
    end
  end

  // Enable is frozen while scanning or clearing so the snapshot is coherent;
  // the programmed enable in en_q is untouched and reappears afterwards.
  assign bus.cov_en    = en_q && !((state_q == ST_SCAN) || (state_q == ST_DRAIN) ||
                                   (state_q == ST_CLEAR));
  assign bus.cov_clr   = (state_q == ST_CLEAR);
  assign bus.cmd_ready = (state_q == ST_IDLE) && !reset;
  assign bus.src_sel   = sel_q;
  assign bus.res_valid = (state_q == ST_RESULT);
  assign bus.res_hit   = hit_q;
  assign bus.res_total = tot_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cov_collect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cov_collect_ctrl                                             |
// | Purpose  : Self-checking bench for cov_collect_ctrl. Two instances run in  |
// |            lockstep (16-bit and 4-bit result counters) against a simple    |
// |            source array and a totals model computed from the bitmaps.      |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cov_collect_ctrl;
  localparam int NS    = 4;
  localparam int PTW   = 16;
  localparam int CW_A  = 16;
  localparam int CW_B  = 4;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_SCAN  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cov_collect_ctrl_if #(.NUM_SRC(NS), .PT_W(PTW), .CNT_W(CW_A)) b0 ();
  cov_collect_ctrl_if #(.NUM_SRC(NS), .PT_W(PTW), .CNT_W(CW_B)) b1 ();

  cov_collect_ctrl #(.NUM_SRC(NS), .PT_W(PTW), .CNT_W(CW_A)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (b0)
  );
  cov_collect_ctrl #(.NUM_SRC(NS), .PT_W(PTW), .CNT_W(CW_B)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (b1)
  );

  // Instrumented-module array: registered read, one cycle after select.
  logic [PTW-1:0] hit_arr  [NS];
  logic [4:0]     npts_arr [NS];

  always @(posedge clock) begin
    b0.src_hit  <= hit_arr[b0.src_sel];
    b0.src_npts <= npts_arr[b0.src_sel];
    b1.src_hit  <= hit_arr[b1.src_sel];
    b1.src_npts <= npts_arr[b1.src_sel];
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit en_model = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_cmd(input bit v, input logic [1:0] op);
    b0.cmd_valid = v;  b1.cmd_valid = v;
    b0.cmd_op    = op; b1.cmd_op    = op;
  endtask

  task automatic set_rr(input bit r);
    b0.res_ready = r;
    b1.res_ready = r;
  endtask

  // Reference totals: per source, clamp the point count to the bitmap width and
  // count set bits below it; result counters clip at their maximum value.
  task automatic exp_sums(output int h, output int t);
    h = 0;
    t = 0;
    for (int k = 0; k < NS; k++) begin
      int n;
      n = (int'(npts_arr[k]) > PTW) ? PTW : int'(npts_arr[k]);
      for (int i = 0; i < n; i++) h += int'(hit_arr[k][i]);
      t += n;
    end
  endtask

  function automatic int clip(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic do_enable(input bit on);
    set_cmd(1'b1, on ? OP_START : OP_STOP);
    check_eq("en_cmd_ready", b0.cmd_ready, 1);
    tick();
    set_cmd(1'b0, OP_START);
    en_model = on;
    check_eq("en_cov_en_a", b0.cov_en, on);
    check_eq("en_cov_en_b", b1.cov_en, on);
  endtask

  task automatic run_scan(input string tag, input int hold, input bit early);
    int eh, et;
    exp_sums(eh, et);
    set_cmd(1'b1, OP_SCAN);
    check_eq({tag, "_cmd_ready"}, b0.cmd_ready, 1);
    if (early) set_rr(1'b1);
    tick();  // cycle T+1
    set_cmd(1'b0, OP_START);
    for (int k = 1; k <= NS + 1; k++) begin
      check_eq({tag, "_cov_en_low"}, b0.cov_en, 0);
      check_eq({tag, "_busy"}, b0.busy, 1);
      check_eq({tag, "_noval_a"}, b0.res_valid, 0);
      check_eq({tag, "_noval_b"}, b1.res_valid, 0);
      check_eq({tag, "_ready_low"}, b0.cmd_ready, 0);
      if (k <= NS) check_eq({tag, "_src_sel"}, b0.src_sel, k - 1);
      tick();
    end
    // cycle T+NS+2
    for (int w = 0; w <= (early ? 0 : hold); w++) begin
      check_eq({tag, "_res_valid_a"}, b0.res_valid, 1);
      check_eq({tag, "_res_valid_b"}, b1.res_valid, 1);
      check_eq({tag, "_cov_en_back"}, b0.cov_en, en_model);
      check_eq({tag, "_hit_a"}, b0.res_hit, clip(eh, CW_A));
      check_eq({tag, "_tot_a"}, b0.res_total, clip(et, CW_A));
      check_eq({tag, "_hit_b"}, b1.res_hit, clip(eh, CW_B));
      check_eq({tag, "_tot_b"}, b1.res_total, clip(et, CW_B));
      if (!early && w < hold) tick();
    end
    set_rr(1'b1);
    tick();
    set_rr(1'b0);
    check_eq({tag, "_valid_drop"}, b0.res_valid, 0);
    check_eq({tag, "_idle"}, b0.busy, 0);
    check_eq({tag, "_ready_back"}, b0.cmd_ready, 1);
    check_eq({tag, "_hit_kept"}, b0.res_hit, clip(eh, CW_A));
    check_eq({tag, "_tot_kept"}, b1.res_total, clip(et, CW_B));
  endtask

  task automatic load_srcs(input logic [15:0] h0, h1, h2, h3,
                           input logic [4:0] n0, n1, n2, n3);
    hit_arr[0] = h0; hit_arr[1] = h1; hit_arr[2] = h2; hit_arr[3] = h3;
    npts_arr[0] = n0; npts_arr[1] = n1; npts_arr[2] = n2; npts_arr[3] = n3;
  endtask

  initial begin
    reset = 1'b1;
    set_cmd(1'b0, OP_START);
    set_rr(1'b0);
    load_srcs(16'h0, 16'h0, 16'h0, 16'h0, 5'd0, 5'd0, 5'd0, 5'd0);

    // Reset state
    @(negedge clock);
    check_eq("rst_cmd_ready", b0.cmd_ready, 0);
    tick();
    check_eq("rst_cmd_ready2", b0.cmd_ready, 0);
    reset = 1'b0;
    tick();
    check_eq("rst_cov_en", b0.cov_en, 0);
    check_eq("rst_cov_clr", b0.cov_clr, 0);
    check_eq("rst_src_sel", b0.src_sel, 0);
    check_eq("rst_res_valid", b0.res_valid, 0);
    check_eq("rst_res_hit", b0.res_hit, 0);
    check_eq("rst_res_total", b0.res_total, 0);
    check_eq("rst_busy", b0.busy, 0);
    check_eq("rst_cmd_ready_up", b0.cmd_ready, 1);

    // START then STOP back-to-back, START again
    do_enable(1'b1);
    do_enable(1'b0);
    do_enable(1'b1);

    // Reference scan: 8+16+1+0 hits of 44 points
    load_srcs(16'h00FF, 16'hFFFF, 16'h0001, 16'h0000, 5'd8, 5'd16, 5'd4, 5'd16);
    run_scan("scan_ref", 2, 1'b0);

    // Masking and clamping of the point count
    load_srcs(16'hFFFF, 16'hFFFF, 16'hF0F0, 16'h8001, 5'd3, 5'd20, 5'd0, 5'd15);
    run_scan("scan_mask", 0, 1'b1);

    // Saturation on the narrow instance: 64/64 clips to 15/15
    load_srcs(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 5'd16, 5'd16, 5'd16, 5'd16);
    do_enable(1'b0);
    run_scan("scan_sat", 1, 1'b0);
    do_enable(1'b1);

    // CLEAR while enabled, with a STOP held behind it
    set_cmd(1'b1, OP_CLEAR);
    tick();  // T+1
    set_cmd(1'b1, OP_STOP);
    check_eq("clr_pulse", b0.cov_clr, 1);
    check_eq("clr_cov_en_low", b0.cov_en, 0);
    check_eq("clr_not_ready", b0.cmd_ready, 0);
    tick();  // T+2
    check_eq("clr_pulse_end", b0.cov_clr, 0);
    check_eq("clr_cov_en_back", b0.cov_en, 1);
    check_eq("clr_ready_back", b0.cmd_ready, 1);
    tick();  // STOP accepted at T+2
    set_cmd(1'b0, OP_START);
    en_model = 1'b0;
    check_eq("clr_stop_after", b0.cov_en, 0);
    check_eq("clr_single_pulse", b0.cov_clr, 0);

    // Randomized scans
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < NS; k++) begin
        hit_arr[k]  = 16'($urandom);
        npts_arr[k] = 5'($urandom_range(0, 22));
      end
      if ($urandom_range(0, 1) == 1) do_enable(1'b1);
      else                           do_enable(1'b0);
      run_scan("scan_rnd", int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a scan
    do_enable(1'b1);
    load_srcs(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 5'd16, 5'd16, 5'd16, 5'd16);
    set_cmd(1'b1, OP_SCAN);
    tick();  // T+1
    set_cmd(1'b0, OP_START);
    tick();  // T+2
    tick();  // T+3
    reset = 1'b1;
    tick();
    check_eq("mid_rst_valid", b0.res_valid, 0);
    check_eq("mid_rst_cov_en", b0.cov_en, 0);
    check_eq("mid_rst_busy", b0.busy, 0);
    check_eq("mid_rst_sel", b0.src_sel, 0);
    reset = 1'b0;
    en_model = 1'b0;
    for (int w = 0; w < 6; w++) begin
      check_eq("post_rst_valid", b0.res_valid, 0);
      check_eq("post_rst_cov_en", b0.cov_en, 0);
      tick();
    end
    run_scan("scan_after_rst", 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
